// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap/saturate limits, clear, load and overflow/underflow flags.
// Latency: one clk edge from inputs to cnt/ovf/unf/err; at_max/at_min are decoded from cnt.
// Backpressure: none; every enabled edge is acted on, and limit hits are reported as pulses plus a sticky err.
module updown_counter_param #(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter bit               SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up,
    input  logic             down,
    output logic [WIDTH-1:0] cnt,
    output logic             at_max,
    output logic             at_min,
    output logic             ovf,
    output logic             unf,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             unf_nxt;
    logic             err_nxt;
    logic             cnt_is_max;
    logic             cnt_is_min;

    assign cnt_is_max = (cnt == MAX_VAL);
    assign cnt_is_min = (cnt == '0);
    assign at_max     = cnt_is_max;
    assign at_min     = cnt_is_min;

    // Limits are tested before the add, so cnt never leaves 0..MAX_VAL even
    // when MAX_VAL is below the natural WIDTH-bit ceiling.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        err_nxt = err;
        if (clr) begin
            cnt_nxt = '0;
            err_nxt = 1'b0;
        end else if (load) begin
            cnt_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (en) begin
            unique case ({up, down})
                2'b10: begin
                    if (cnt_is_max) begin
                        ovf_nxt = 1'b1;
                        err_nxt = 1'b1;
                        cnt_nxt = SATURATE ? MAX_VAL : '0;
                    end else begin
                        cnt_nxt = cnt + ONE;
                    end
                end
                2'b01: begin
                    if (cnt_is_min) begin
                        unf_nxt = 1'b1;
                        err_nxt = 1'b1;
                        cnt_nxt = SATURATE ? '0 : MAX_VAL;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
                default: cnt_nxt = cnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
            err <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            ovf <= ovf_nxt;
            unf <= unf_nxt;
            err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three instances (wrap 0..9, saturate 0..9, wrap 0..255)
// share one directed stimulus stream and are checked each cycle against an integer model.
module tb_updown_counter_param;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       en = 1'b0, clr = 1'b0, load = 1'b0, up = 1'b0, down = 1'b0;
    logic [7:0] load_val = '0;

    logic [3:0] cnt_w, cnt_s;
    logic [7:0] cnt_d;
    logic       amax_w, amin_w, ovf_w, unf_w, err_w;
    logic       amax_s, amin_s, ovf_s, unf_s, err_s;
    logic       amax_d, amin_d, ovf_d, unf_d, err_d;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .up(up), .down(down), .cnt(cnt_w),
        .at_max(amax_w), .at_min(amin_w), .ovf(ovf_w), .unf(unf_w), .err(err_w));

    updown_counter_param #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .up(up), .down(down), .cnt(cnt_s),
        .at_max(amax_s), .at_min(amin_s), .ovf(ovf_s), .unf(unf_s), .err(err_s));

    updown_counter_param u_def (
        .clk(clk), .reset_n(reset_n), .en(en), .clr(clr), .load(load),
        .load_val(load_val), .up(up), .down(down), .cnt(cnt_d),
        .at_max(amax_d), .at_min(amin_d), .ovf(ovf_d), .unf(unf_d), .err(err_d));

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: plain integer counters per instance.
    int m_cnt[3] = '{0, 0, 0};
    bit m_ovf[3] = '{0, 0, 0};
    bit m_unf[3] = '{0, 0, 0};
    bit m_err[3] = '{0, 0, 0};

    function automatic int maxv(input int k);
        return (k == 2) ? 255 : 9;
    endfunction

    function automatic bit satv(input int k);
        return (k == 1);
    endfunction

    function automatic int lvv(input int k);
        return (k == 2) ? int'(load_val) : int'(load_val[3:0]);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                m_cnt[k] = 0; m_ovf[k] = 0; m_unf[k] = 0; m_err[k] = 0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                m_ovf[k] = 0;
                m_unf[k] = 0;
                if (clr) begin
                    m_cnt[k] = 0;
                    m_err[k] = 0;
                end else if (load) begin
                    m_cnt[k] = (lvv(k) > maxv(k)) ? maxv(k) : lvv(k);
                end else if (en && up && !down) begin
                    if (m_cnt[k] == maxv(k)) begin
                        m_ovf[k] = 1; m_err[k] = 1;
                        m_cnt[k] = satv(k) ? maxv(k) : 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end else if (en && down && !up) begin
                    if (m_cnt[k] == 0) begin
                        m_unf[k] = 1; m_err[k] = 1;
                        m_cnt[k] = satv(k) ? 0 : maxv(k);
                    end else begin
                        m_cnt[k] = m_cnt[k] - 1;
                    end
                end
            end
        end
    end

    task automatic cmp_inst(input int k, input int c, input bit amx, input bit amn,
                            input bit o, input bit u, input bit e);
        string p;
        p = $sformatf("inst%0d", k);
        check({p, " cnt"},    c,   m_cnt[k]);
        check({p, " at_max"}, amx, int'(m_cnt[k] == maxv(k)));
        check({p, " at_min"}, amn, int'(m_cnt[k] == 0));
        check({p, " ovf"},    o,   m_ovf[k]);
        check({p, " unf"},    u,   m_unf[k]);
        check({p, " err"},    e,   m_err[k]);
    endtask

    always @(negedge clk) begin
        cmp_inst(0, int'(cnt_w), amax_w, amin_w, ovf_w, unf_w, err_w);
        cmp_inst(1, int'(cnt_s), amax_s, amin_s, ovf_s, unf_s, err_s);
        cmp_inst(2, int'(cnt_d), amax_d, amin_d, ovf_d, unf_d, err_d);
    end

    task automatic cyc(input bit e, input bit c, input bit l, input int lv,
                       input bit u, input bit d);
        en = e; clr = c; load = l; load_val = 8'(lv); up = u; down = d;
        @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset cnt_d", int'(cnt_d), 0);
        check("reset at_min_d", int'(amin_d), 1);
        check("reset at_max_w", int'(amax_w), 0);
        check("reset err_w", int'(err_w), 0);
        reset_n = 1'b1;

        repeat (5) cyc(1, 0, 0, 0, 1, 0);
        check("count5 cnt_d", int'(cnt_d), 5);
        check("count5 cnt_w", int'(cnt_w), 5);
        check("count5 at_min_d", int'(amin_d), 0);
        check("count5 ovf_d", int'(ovf_d), 0);

        // Asynchronous reset between edges takes effect without a clock.
        #2 reset_n = 1'b0;
        #1;
        check("async rst cnt_d", int'(cnt_d), 0);
        check("async rst cnt_s", int'(cnt_s), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        en = 0; up = 0;

        cyc(0, 0, 1, 9, 0, 0);
        cyc(1, 0, 0, 0, 1, 0);
        check("wrap up cnt_w", int'(cnt_w), 0);
        check("wrap up ovf_w", int'(ovf_w), 1);
        check("wrap up err_w", int'(err_w), 1);
        check("sat up cnt_s", int'(cnt_s), 9);
        check("def up cnt_d", int'(cnt_d), 10);
        cyc(1, 0, 0, 0, 0, 1);
        check("wrap down cnt_w", int'(cnt_w), 9);
        check("wrap down unf_w", int'(unf_w), 1);
        check("wrap ovf one-shot", int'(ovf_w), 0);

        cyc(0, 0, 1, 9, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 1, 0);
            check("sat hold cnt_s", int'(cnt_s), 9);
            check("sat hold ovf_s", int'(ovf_s), 1);
            check("sat hold at_max_s", int'(amax_s), 1);
        end

        cyc(0, 0, 1, 15, 0, 0);
        check("clamp cnt_w", int'(cnt_w), 9);
        check("noclamp cnt_d", int'(cnt_d), 15);

        cyc(0, 1, 1, 3, 0, 0);
        check("clr>load cnt_w", int'(cnt_w), 0);
        check("clr err_s", int'(err_s), 0);

        cyc(0, 0, 1, 9, 0, 0);
        cyc(1, 0, 1, 4, 1, 0);
        check("load>up cnt_w", int'(cnt_w), 4);
        check("load>up ovf_w", int'(ovf_w), 0);

        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0, 1, 1);
            check("hold11 cnt_w", int'(cnt_w), 4);
            check("hold11 ovf|unf", int'(ovf_w | unf_w), 0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            check("hold en0 cnt_w", int'(cnt_w), 4);
            check("hold en0 ovf|unf", int'(ovf_w | unf_w), 0);
        end

        cyc(0, 1, 0, 0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 256; i++) begin
            cyc(1, 0, 0, 0, 1, 0);
            if (ovf_d) pulses++;
            if (i == 254) check("full 255th cnt_d", int'(cnt_d), 255);
        end
        check("full 256th cnt_d", int'(cnt_d), 0);
        check("full 256th ovf_d", int'(ovf_d), 1);
        check("full ovf pulses", pulses, 1);

        cyc(0, 1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        check("unf wrap cnt_w", int'(cnt_w), 9);
        check("unf sat cnt_s", int'(cnt_s), 0);
        check("unf sat unf_s", int'(unf_s), 1);
        check("unf def cnt_d", int'(cnt_d), 255);

        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
